msx_mux_scanner: RTL

Parametrised multiplexed-input scanner for the MSX cartridge edge. It time-multiplexes `GROUPS` external buffers onto one `WIDTH`-bit pin bus and deglitches each captured bit. It also filters and delays the direct strobe pins, and publishes a frame-coherent snapshot plus a one-cycle frame-done pulse. It sits between the board pins and the board bus adapter, and replaces the fixed 3×8 scan with a configurable one.

---
 rtl/msx_mux_scanner.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/msx_mux_scanner.sv
// Multiplexed-input scanner: walks the enabled buffer groups over one pin bus, deglitches
// every captured bit, filters and delays the direct strobes, and publishes a per-frame snapshot.
module msx_mux_scanner #(
  parameter int GROUPS  = 3,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 2,
  parameter int SAMPLES = 2,
  parameter int FILTER  = 2,
  parameter int STROBES = 2,
  parameter int DELAY   = 9,
  parameter bit DEFAULT = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [WIDTH-1:0]        MUX_SIG,
  input  logic [GROUPS-1:0]       GROUP_EN,
  input  logic [STROBES-1:0]      STROBE_IN,
  output logic [GROUPS-1:0]       MUX_CS_n,
  output logic [GROUPS*WIDTH-1:0] LIVE,
  output logic [GROUPS*WIDTH-1:0] SNAP,
  output logic                    FRAME_DONE,
  output logic [STROBES-1:0]      STROBE_OUT,
  output logic [STROBES-1:0]      STROBE_FALL
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int NB = GROUPS * WIDTH;
  localparam int RW = 3;
  localparam logic [RW-1:0] RUN_MAX     = RW'(FILTER);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]    SAMPLE_LAST = 4'(SAMPLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_e;

  // With no settle time a slot opens directly in its sampling phase.
  localparam state_e SLOT_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  // Length of the current run of equal samples, saturating once it is long enough to count.
  function automatic logic [RW-1:0] run_next(input logic s, input logic last,
                                             input logic [RW-1:0] run);
    if (s != last)       return RW'(1);
    if (run >= RUN_MAX)  return RUN_MAX;
    return run + RW'(1);
  endfunction

  // ---------------------------------------------------------------- slot FSM
  state_e            state_q, state_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [GROUPS-1:0] cs_q, cs_d;
  logic              frame_q, frame_d;
  logic              sample_en;

  logic [GW-1:0] lowest, above;
  logic          any_en, has_above;

  always_comb begin
    lowest    = '0;
    above     = '0;
    any_en    = 1'b0;
    has_above = 1'b0;
    for (int g = GROUPS - 1; g >= 0; g--) begin
      if (GROUP_EN[g]) begin
        lowest = GW'(g);
        any_en = 1'b1;
        if (GW'(g) > grp_q) begin
          above     = GW'(g);
          has_above = 1'b1;
        end
      end
    end
  end

  // NOTE: every variable gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    frame_d   = 1'b0;
    sample_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_en) begin
          state_d = SLOT_FIRST;
          grp_d   = lowest;
          cnt_d   = '0;
          cs_d    = ~(GROUPS'(1) << lowest);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (cnt_q != SAMPLE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!any_en) begin
          state_d = ST_IDLE;
          cs_d    = '1;
        end else begin
          // Wrapping back to the lowest enabled group closes the frame.
          state_d = SLOT_FIRST;
          cnt_d   = '0;
          grp_d   = has_above ? above : lowest;
          cs_d    = ~(GROUPS'(1) << grp_d);
          frame_d = !has_above;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= SLOT_FIRST;
      grp_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= ~GROUPS'(1);
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      frame_q <= frame_d;
    end
  end

  // ---------------------------------------------------------------- bit filters
  logic [NB-1:0] live_q, live_d, last_q, last_d, snap_q;
  logic [RW-1:0] run_q [NB];
  logic [RW-1:0] run_d [NB];

  always_comb begin
    live_d = live_q;
    last_d = last_q;
    run_d  = run_q;
    if (sample_en) begin
      for (int b = 0; b < NB; b++) begin
        if (b / WIDTH == int'(grp_q)) begin
          run_d[b]  = run_next(MUX_SIG[b % WIDTH], last_q[b], run_q[b]);
          last_d[b] = MUX_SIG[b % WIDTH];
          if (run_d[b] >= RUN_MAX) live_d[b] = MUX_SIG[b % WIDTH];
        end
      end
    end
  end

  // NOTE: the run-counter array is ordinary flops, so it is reset like any other register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      live_q <= {NB{DEFAULT}};
      last_q <= {NB{DEFAULT}};
      snap_q <= {NB{DEFAULT}};
      for (int b = 0; b < NB; b++) run_q[b] <= '0;
    end else begin
      live_q <= live_d;
      last_q <= last_d;
      run_q  <= run_d;
      // Snapshot takes the post-sample value so the frame's final sample is included.
      if (frame_d) snap_q <= live_d;
    end
  end

  // ---------------------------------------------------------------- strobes
  logic [STROBES-1:0] sfilt_q, sfilt_d, slast_q, strobe_dly, prev_q, fall_q;
  logic [RW-1:0]      srun_q [STROBES];
  logic [RW-1:0]      srun_d [STROBES];

  always_comb begin
    sfilt_d = sfilt_q;
    for (int i = 0; i < STROBES; i++) begin
      srun_d[i] = run_next(STROBE_IN[i], slast_q[i], srun_q[i]);
      if (srun_d[i] >= RUN_MAX) sfilt_d[i] = STROBE_IN[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sfilt_q <= {STROBES{DEFAULT}};
      slast_q <= {STROBES{DEFAULT}};
      prev_q  <= {STROBES{DEFAULT}};
      fall_q  <= '0;
      for (int i = 0; i < STROBES; i++) srun_q[i] <= '0;
    end else begin
      sfilt_q <= sfilt_d;
      slast_q <= STROBE_IN;
      srun_q  <= srun_d;
      prev_q  <= strobe_dly;
      fall_q  <= ~strobe_dly & prev_q;
    end
  end

  generate
    if (DELAY == 0) begin : g_no_delay
      assign strobe_dly = sfilt_q;
    end else begin : g_delay
      logic [STROBES-1:0] dly_q [DELAY];
      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          for (int i = 0; i < DELAY; i++) dly_q[i] <= {STROBES{DEFAULT}};
        end else begin
          dly_q[0] <= sfilt_q;
          for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign strobe_dly = dly_q[DELAY-1];
    end
  endgenerate

  assign MUX_CS_n    = cs_q;
  assign LIVE        = live_q;
  assign SNAP        = snap_q;
  assign FRAME_DONE  = frame_q;
  assign STROBE_OUT  = strobe_dly;
  assign STROBE_FALL = fall_q;

endmodule
